fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'd100, meaning the byte address loaded into the PC on reset (word-aligned).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port stall, input, 1, hazard hold request from the hazard unit.
REQ-005 SHALL have port branch_taken, input, 1, taken-branch redirect from the ID stage.
REQ-006 SHALL have port branch_target, input, 32, branch byte target computed by ID as ifid_pc4 + (signext(imm16) << 2).
REQ-007 SHALL have port jump, input, 1, jump redirect from the ID stage.
REQ-008 SHALL have port jump_index, input, 26, jump instruction index field.
REQ-009 SHALL have port pc, output, 32, byte address driven to the instruction memory PC input.
REQ-010 SHALL have port instruction, input, 32, combinational big-endian word returned by the instruction memory for pc.
REQ-011 SHALL have port ifid_instr, output, 32, IF/ID registered instruction.
REQ-012 SHALL have port ifid_pc4, output, 32, IF/ID registered address of that instruction plus 4.
REQ-013 SHALL have port ifid_valid, output, 1, IF/ID holds a real fetched instruction.
REQ-014 SHALL have port align_err, output, 1, sticky flag for a misaligned redirect target.

Function
REQ-015 SHALL register pc, ifid_instr, ifid_pc4, ifid_valid and align_err; no output is combinational from inputs.
REQ-016 SHALL apply the update rules per cycle in strict priority: reset > branch_taken > jump > stall > sequential.
REQ-017 Sequential update (none asserted): pc <= pc+4; ifid_instr <= instruction; ifid_pc4 <= pc+4; ifid_valid <= 1.
REQ-018 Stall update: pc, ifid_instr, ifid_pc4, ifid_valid and align_err hold their values.
REQ-019 Branch update: pc <= {branch_target[31:2], 2'b00}; ifid_instr <= 0; ifid_pc4 <= 0; ifid_valid <= 0 (one-bubble flush).
REQ-020 Branch update: align_err <= align_err | (branch_target[1:0] != 0).
REQ-021 Jump update: pc <= {ifid_pc4[31:28], jump_index, 2'b00}; IF/ID flushed as in REQ-019; align_err unchanged.
REQ-022 branch_taken and jump both asserted: branch wins and jump is ignored.
REQ-023 branch_taken or jump SHALL override stall in the same cycle.
REQ-024 PC increment SHALL be modulo 2^32 (32'hFFFFFFFC + 4 = 0); no saturation or error.
REQ-025 Fetch latency SHALL be one cycle: the word at pc appears on ifid_instr after the next rising edge unless stalled or flushed.
REQ-026 ifid_valid=0 entries SHALL carry ifid_instr=0 (MIPS nop) so downstream decode is harmless.

Reset
REQ-027 On reset=1 at a rising edge: pc <= RESET_PC; ifid_instr <= 0; ifid_pc4 <= 0; ifid_valid <= 0; align_err <= 0.
REQ-028 Reset SHALL take effect mid-stall or mid-redirect, discarding all pending state.
REQ-029 Before the first reset edge, outputs are undefined; the bench SHALL not check them.

Verification
REQ-030 RESET_PC=100, reset 1 cycle, then 3 free cycles -> pc 100,104,108,112; after the first free edge ifid_pc4=104, ifid_instr=32'h48080000, ifid_valid=1.
REQ-031 pc=108, stall=1 for 2 cycles -> pc=108 and IF/ID unchanged both cycles; stall released -> pc=112, ifid_pc4=112.
REQ-032 stall=1 with branch_taken=1 and branch_target=500 -> pc=500, ifid_valid=0, ifid_instr=0; next free edge -> ifid_pc4=504.
REQ-033 ifid_pc4=708, jump=1, jump_index=179 -> pc=716, IF/ID flushed.
REQ-034 branch_taken=1 with branch_target=32'h1F6 and jump=1 in the same cycle -> pc=32'h1F4, align_err=1; align_err stays 1 through later cycles until reset.
REQ-035 pc=32'hFFFFFFFC, free cycle -> pc=0, ifid_pc4=0, ifid_valid=1; reset asserted during stall -> pc=RESET_PC, ifid_valid=0.

Source files
------------

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage pipeline: owns the PC and the IF/ID register.
// Redirects from ID flush IF/ID with a nop bubble, and stalls freeze everything.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'd100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] pc,
  input  logic [31:0] instruction,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        align_err
);

  logic [31:0] pc_plus4;
  logic [31:0] branch_pc;
  logic [31:0] jump_pc;
  logic        branch_misaligned;

  // The jump region comes from the delay-slot address held in IF/ID, not from the current pc.
  always_comb begin
    pc_plus4          = pc + 32'd4;
    branch_pc         = {branch_target[31:2], 2'b00};
    jump_pc           = {ifid_pc4[31:28], jump_index, 2'b00};
    branch_misaligned = |branch_target[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      ifid_instr <= 32'd0;
      ifid_pc4   <= 32'd0;
      ifid_valid <= 1'b0;
      align_err  <= 1'b0;
    end else if (branch_taken) begin
      pc         <= branch_pc;
      ifid_instr <= 32'd0;
      ifid_pc4   <= 32'd0;
      ifid_valid <= 1'b0;
      align_err  <= align_err | branch_misaligned;
    end else if (jump) begin
      pc         <= jump_pc;
      ifid_instr <= 32'd0;
      ifid_pc4   <= 32'd0;
      ifid_valid <= 1'b0;
    end else if (!stall) begin
      pc         <= pc_plus4;
      ifid_instr <= instruction;
      ifid_pc4   <= pc_plus4;
      ifid_valid <= 1'b1;
    end
  end

endmodule
